// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned
// divisor -> 16-bit quotient, 8-bit remainder. One quotient bit is resolved
// per clock (MSB first), so a division takes 16 RUN cycles plus a one-cycle
// DONE state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request; accepted only in IDLE or DONE
//   dividend   16-bit dividend, captured when start is accepted
//   divisor    8-bit divisor, captured when start is accepted
//   busy       high while a division is in progress
//   done       one-cycle pulse; quotient/remainder/err valid from this cycle
//   quotient   16-bit quotient, held until the next division completes
//   remainder  8-bit remainder, held until the next division completes
//   err        divide-by-zero flag (only driven with the macro below)
//
// Handshake: start is sampled on a rising edge while busy is low. Once
// accepted, busy stays high until done pulses; further start pulses and
// operand changes are ignored until then. start may be held high in the
// DONE cycle to chain the next division with no idle bubble.
//
// Configuration macro: SEQ_DIVIDER_ZERO_CHK_EN
//   defined   : divisor 0 bypasses the iterations (done 2 cycles after the
//               start edge), quotient=16'hFFFF, remainder=dividend[7:0], err=1
//   undefined : err is always 0; divisor 0 runs the full iteration and
//               naturally yields the same quotient/remainder values
// ---------------------------------------------------------------------------
module seq_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        err
);

   // ZERO is the single bypass cycle for a zero divisor; it is only reachable
   // when the zero-check macro is defined.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ZERO = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   // work: dividend bits leave at the MSB while quotient bits enter at the
   // LSB, so after 16 shifts it holds the complete quotient.
   logic [15:0] work;
   logic [7:0]  dvs;
   logic [7:0]  part_r;
   logic [3:0]  count;

   logic        accept;
   logic        zero_div;
   logic [8:0]  r_shift;
   logic [8:0]  r_sub;
   logic        q_bit;
   logic [7:0]  r_next;

   assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef SEQ_DIVIDER_ZERO_CHK_EN
   assign zero_div = (divisor == 8'd0);
`else
   assign zero_div = 1'b0;
`endif

   // One restoring step. After a subtraction the result is below the divisor
   // and fits in 8 bits; with a zero divisor the 9th bit is simply dropped,
   // which leaves the last eight dividend bits as the remainder.
   always_comb begin
      r_shift = {part_r, work[15]};
      q_bit   = (r_shift >= {1'b0, dvs});
      r_sub   = r_shift - {1'b0, dvs};
      r_next  = q_bit ? r_sub[7:0] : r_shift[7:0];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and status outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = zero_div ? ZERO : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == 4'd0) begin
               state_nx = DONE;
            end
         end
         ZERO: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (accept) begin
               state_nx = zero_div ? ZERO : RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Datapath. quotient/remainder are loaded only on the edge that enters
   // DONE, so they keep the previous result during RUN and through IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work      <= 16'd0;
         dvs       <= 8'd0;
         part_r    <= 8'd0;
         count     <= 4'd0;
         quotient  <= 16'd0;
         remainder <= 8'd0;
         err       <= 1'b0;
      end else if (accept) begin
         work   <= dividend;
         dvs    <= divisor;
         part_r <= 8'd0;
         count  <= 4'd15;
         err    <= zero_div;
      end else if (state == RUN) begin
         work   <= {work[14:0], q_bit};
         part_r <= r_next;
         count  <= count - 4'd1;
         if (count == 4'd0) begin
            quotient  <= {work[14:0], q_bit};
            remainder <= r_next;
         end
      end else if (state == ZERO) begin
         // work still holds the untouched dividend here
         quotient  <= 16'hFFFF;
         remainder <= work[7:0];
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider. A transaction-level model predicts, per clock edge,
// whether the divider is busy, when done must pulse and which result must be
// on the outputs (computed with / and %). A compare process checks every
// output against that model on each falling edge. Directed tasks add
// hand-computed literal expectations for latency and results.
// ---------------------------------------------------------------------------
module tb_seq_divider;

`ifdef SEQ_DIVIDER_ZERO_CHK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = 16'd0;
   logic [7:0]  divisor = 8'd0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        err;

   always #5 clk = ~clk;

   seq_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks = checks + 1;
      if (act !== exp_v) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   // exp_q holds {quotient, remainder} for accepted, not yet finished ops.
   logic [23:0] exp_q[$];
   int          m_edge = 0;
   int          m_done_edge = 0;
   bit          m_run = 1'b0;
   bit          m_was_busy;
   bit          m_zc;
   logic [15:0] m_q = 16'd0;
   logic [7:0]  m_r = 8'd0;
   logic        m_err = 1'b0;
   logic [15:0] t_q;
   logic [7:0]  t_r;

   always begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_edge      = 0;
         m_done_edge = 0;
         m_run       = 1'b0;
         m_q         = 16'd0;
         m_r         = 8'd0;
         m_err       = 1'b0;
         exp_q.delete();
      end else begin
         m_was_busy = m_run && (m_edge < m_done_edge);
         m_edge     = m_edge + 1;
         if (m_run && (m_edge == m_done_edge) && (exp_q.size() > 0)) begin
            {m_q, m_r} = exp_q.pop_front();
         end
         if (start && !m_was_busy) begin
            m_zc = ZCHK && (divisor == 8'd0);
            if (divisor == 8'd0) begin
               t_q = 16'hFFFF;
               t_r = dividend[7:0];
            end else begin
               t_q = dividend / {8'd0, divisor};
               t_r = 8'(dividend % {8'd0, divisor});
            end
            exp_q.push_back({t_q, t_r});
            m_done_edge = m_edge + (m_zc ? 1 : 16);
            m_run       = 1'b1;
            m_err       = m_zc;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      @(negedge clk);
      if (!rst) begin
         chk("busy", busy, m_run && (m_edge < m_done_edge));
         chk("done", done, m_run && (m_edge == m_done_edge));
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("err", err, m_err);
      end
   end

   // ---------------- driver tasks ----------------
   // Called right after a falling edge; returns one falling edge later with
   // the operands scrambled to show they are not re-sampled.
   task automatic go(input logic [15:0] a, input logic [7:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   // Counts falling edges since the start edge; bounded.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n = n + 1;
      end
   endtask

   task automatic op(input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] eq, input logic [7:0] er,
                     input int elat, input logic eerr);
      int n;
      go(a, b);
      wait_done(n);
      chk("latency", n, elat);
      chk("lit_quotient", quotient, eq);
      chk("lit_remainder", remainder, er);
      chk("lit_busy_in_done", busy, 1'b0);
      chk("lit_err", err, eerr);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [15:0] a16;
      logic [7:0]  b8;
      int          pa;
      int          pb;

      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_quotient", quotient, 16'd0);
      chk("rst_remainder", remainder, 8'd0);
      chk("rst_err", err, 1'b0);

      @(negedge clk);
      rst = 1'b0;

      // first start taken on the first rising edge after reset release
      op(16'h03E8, 8'h07, 16'h008E, 8'h06, 17, 1'b0);
      op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 17, 1'b0);
      op(16'h0005, 8'h09, 16'h0000, 8'h05, 17, 1'b0);
      op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 17, 1'b0);
      op(16'h1234, 8'h00, 16'hFFFF, 8'h34, ZCHK ? 2 : 17, ZCHK);

      // back-to-back from the DONE cycle, with start pulses during RUN
      go(16'h00FF, 8'h10);
      n = 1;
      while (!done && n < 40) begin
         if (n == 4 || n == 9) begin
            start    = 1'b1;
            dividend = 16'hAAAA;
            divisor  = 8'h03;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n = n + 1;
      end
      start = 1'b0;
      chk("b2b_latency", n, 17);
      chk("b2b_quotient", quotient, 16'h000F);
      chk("b2b_remainder", remainder, 8'h0F);
      chk("b2b_err_cleared", err, 1'b0);

      // reset in the middle of an operation
      go(16'h03E8, 8'h07);
      repeat (7) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_quotient", quotient, 16'd0);
      chk("midrst_remainder", remainder, 8'd0);
      chk("midrst_err", err, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // compare process flags any stray done pulse here
      repeat (20) @(negedge clk);
      op(16'h0064, 8'h0A, 16'd10, 8'd0, 17, 1'b0);

      // random products of the 8x8 multiplier as dividends, chained
      for (int i = 0; i < 1000; i++) begin
         pa  = $urandom_range(0, 255);
         pb  = $urandom_range(0, 255);
         a16 = 16'(pa * pb);
         b8  = 8'($urandom_range(1, 255));
         go(a16, b8);
         wait_done(n);
         chk("rnd_latency", n, 17);
         chk("rnd_identity", int'(quotient) * int'(b8) + int'(remainder), {16'd0, a16});
         chk("rnd_rem_lt_div", remainder < b8, 1'b1);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
